fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, issues in-order requests to a variable-latency instruction memory, buffers returned words, and drives the IF/ID pipeline register (current PC plus instruction, with a valid flag) consumed by decode. It honours a hazard stall from decode and a branch/jump redirect from execute, discarding wrong-path instructions that are already in flight.

---
 rtl/fetch_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage RISC-V pipeline. Owns the program
// counter, issues in-order requests to a variable-latency instruction memory,
// buffers returned words and drives the IF/ID register consumed by decode.
// A hazard stall freezes IF/ID. A redirect from EX retargets the PC and
// discards every wrong-path word that is still in flight.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   imem_req     fetch request valid
//   imem_addr    fetch byte address (current PC)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  response valid (in request order, >= 1 cycle after accept)
//   imem_rdata   response instruction word
//   stall        hold the IF/ID outputs
//   redirect     taken branch/jump, flush the front end
//   redirect_pc  new fetch target
//   ifid_valid   IF/ID holds a real instruction (0 = bubble)
//   ifid_pc      PC of the instruction in IF/ID
//   ifid_instr   instruction in IF/ID
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               ifid_valid,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

    // Circular pointer advance that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Architectural state
    logic [PC_W-1:0]    pc_reg,         pc_next;
    logic [CNT_W-1:0]   inflight_reg,   inflight_next;
    logic [CNT_W-1:0]   drop_cnt_reg,   drop_cnt_next;

    // Return buffer of {pc, instr}
    logic [PC_W-1:0]    buf_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] buf_instr_mem [DEPTH];
    logic [CNT_W-1:0]   buf_count_reg,  buf_count_next;
    logic [PTR_W-1:0]   buf_rd_ptr_reg, buf_rd_ptr_next;
    logic [PTR_W-1:0]   buf_wr_ptr_reg, buf_wr_ptr_next;

    // Addresses of outstanding requests, popped by every response (kept or not)
    logic [PC_W-1:0]    pcq_mem [DEPTH];
    logic [PTR_W-1:0]   pcq_rd_ptr_reg, pcq_rd_ptr_next;
    logic [PTR_W-1:0]   pcq_wr_ptr_reg, pcq_wr_ptr_next;

    // IF/ID register
    logic               ifid_valid_reg, ifid_valid_next;
    logic [PC_W-1:0]    ifid_pc_reg,    ifid_pc_next;
    logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;

    // Per-cycle control
    logic [CNT_W:0]     credit_sum;
    logic               issue_ok;
    logic               accept;
    logic               advance;
    logic               buf_empty;
    logic               drop_resp;
    logic               keep_resp;
    logic               buf_push;
    logic               buf_pop;
    logic               bypass;
    logic [PC_W-1:0]    resp_pc;

    // Credit: in-flight requests plus buffered words never exceed DEPTH, so
    // every response that is kept always has a buffer slot to land in.
    assign credit_sum = {1'b0, inflight_reg} + {1'b0, buf_count_reg};
    assign issue_ok   = credit_sum < DEPTH_W;

    // Gating with reset keeps the request low while reset is asserted even
    // though the cleared counters would otherwise grant credit.
    assign imem_req  = reset && !redirect && issue_ok;
    assign imem_addr = pc_reg;

    assign accept    = imem_req && imem_ready;
    assign advance   = !stall && !redirect;
    assign buf_empty = (buf_count_reg == '0);
    assign resp_pc   = pcq_mem[pcq_rd_ptr_reg];

    // A response is wrong-path if older drops are pending or a redirect is
    // happening in the very same cycle.
    assign drop_resp = imem_rvalid && (redirect || (drop_cnt_reg != '0));
    assign keep_resp = imem_rvalid && !drop_resp;
    assign buf_pop   = advance && !buf_empty;
    assign bypass    = keep_resp && advance && buf_empty;
    assign buf_push  = keep_resp && !bypass;

    always_comb begin
        pc_next         = pc_reg;
        inflight_next   = inflight_reg;
        drop_cnt_next   = drop_cnt_reg;
        buf_count_next  = buf_count_reg;
        buf_rd_ptr_next = buf_rd_ptr_reg;
        buf_wr_ptr_next = buf_wr_ptr_reg;
        pcq_rd_ptr_next = pcq_rd_ptr_reg;
        pcq_wr_ptr_next = pcq_wr_ptr_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;

        // Program counter; the add wraps naturally at 2^PC_W.
        if (redirect) begin
            pc_next = redirect_pc;
        end else if (accept) begin
            pc_next = pc_reg + PC_W'(4);
        end

        // Accept and response in the same cycle cancel out.
        case ({accept, imem_rvalid})
            2'b10:   inflight_next = inflight_reg + CNT_W'(1);
            2'b01:   inflight_next = inflight_reg - CNT_W'(1);
            default: inflight_next = inflight_reg;
        endcase

        // Everything in flight at redirect time is stale; a response in the
        // redirect cycle is already being discarded, so it is not counted.
        if (redirect) begin
            drop_cnt_next = imem_rvalid ? (inflight_reg - CNT_W'(1)) : inflight_reg;
        end else if (imem_rvalid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - CNT_W'(1);
        end

        if (accept) begin
            pcq_wr_ptr_next = next_ptr(pcq_wr_ptr_reg);
        end
        if (imem_rvalid) begin
            pcq_rd_ptr_next = next_ptr(pcq_rd_ptr_reg);
        end

        // Return buffer
        if (redirect) begin
            buf_count_next  = '0;
            buf_rd_ptr_next = '0;
            buf_wr_ptr_next = '0;
        end else begin
            if (buf_push) begin
                buf_wr_ptr_next = next_ptr(buf_wr_ptr_reg);
            end
            if (buf_pop) begin
                buf_rd_ptr_next = next_ptr(buf_rd_ptr_reg);
            end
            case ({buf_push, buf_pop})
                2'b10:   buf_count_next = buf_count_reg + CNT_W'(1);
                2'b01:   buf_count_next = buf_count_reg - CNT_W'(1);
                default: buf_count_next = buf_count_reg;
            endcase
        end

        // IF/ID: oldest buffered word first, then a fresh response, else a
        // bubble. During a stall (and no redirect) everything is held.
        if (redirect) begin
            ifid_valid_next = 1'b0;
        end else if (advance) begin
            if (!buf_empty) begin
                ifid_valid_next = 1'b1;
                ifid_pc_next    = buf_pc_mem[buf_rd_ptr_reg];
                ifid_instr_next = buf_instr_mem[buf_rd_ptr_reg];
            end else if (bypass) begin
                ifid_valid_next = 1'b1;
                ifid_pc_next    = resp_pc;
                ifid_instr_next = imem_rdata;
            end else begin
                ifid_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg         <= '0;
            inflight_reg   <= '0;
            drop_cnt_reg   <= '0;
            buf_count_reg  <= '0;
            buf_rd_ptr_reg <= '0;
            buf_wr_ptr_reg <= '0;
            pcq_rd_ptr_reg <= '0;
            pcq_wr_ptr_reg <= '0;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= '0;
        end else begin
            pc_reg         <= pc_next;
            inflight_reg   <= inflight_next;
            drop_cnt_reg   <= drop_cnt_next;
            buf_count_reg  <= buf_count_next;
            buf_rd_ptr_reg <= buf_rd_ptr_next;
            buf_wr_ptr_reg <= buf_wr_ptr_next;
            pcq_rd_ptr_reg <= pcq_rd_ptr_next;
            pcq_wr_ptr_reg <= pcq_wr_ptr_next;
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
        end
    end

    // Storage arrays carry no reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr_ptr_reg] <= pc_reg;
        end
        if (buf_push) begin
            buf_pc_mem[buf_wr_ptr_reg]    <= resp_pc;
            buf_instr_mem[buf_wr_ptr_reg] <= imem_rdata;
        end
    end

    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A small in-order memory model answers each
// accepted request a fixed number of cycles later with
// instr = 0x00000013 | (addr << 20). Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               ifid_valid;
    logic [PC_W-1:0]    ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;

    int total = 0;
    int bad   = 0;

    // memory model state
    int lat  = 1;
    int mcyc = 0;
    int addr_q[$];
    int due_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    // Memory: record accepts and retire responses on the rising edge.
    always @(posedge clk) begin
        if (!reset) begin
            addr_q.delete();
            due_q.delete();
        end else begin
            if (imem_rvalid && (addr_q.size() > 0)) begin
                void'(addr_q.pop_front());
                void'(due_q.pop_front());
            end
            if (imem_req && imem_ready) begin
                addr_q.push_back(int'(imem_addr));
                due_q.push_back(mcyc + lat);
            end
        end
        mcyc++;
    end

    // Memory: present the oldest response once it is due.
    always @(negedge clk) begin
        if (reset && (addr_q.size() > 0) && (due_q[0] <= mcyc)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h13 | (32'(addr_q[0]) << 20);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // IF/ID holds a valid instruction fetched from exp_pc.
    task automatic chk_out(input string tag, input logic [PC_W-1:0] exp_pc);
        chk({tag, ".valid"}, 32'(ifid_valid), 32'd1);
        chk({tag, ".pc"}, 32'(ifid_pc), 32'(exp_pc));
        chk({tag, ".instr"}, ifid_instr, 32'h13 | (32'(exp_pc) << 20));
        $display("ifid %s pc=0x%03h instr=0x%08h valid=%0b", tag, ifid_pc, ifid_instr, ifid_valid);
    endtask

    task automatic chk_req(input string tag, input logic exp_req, input logic [PC_W-1:0] exp_addr);
        chk({tag, ".req"}, 32'(imem_req), 32'(exp_req));
        if (exp_req) begin
            chk({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic [PC_W-1:0] rpc, input logic rdy);
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        stall      = 1'b0;
        redirect   = 1'b0;
        imem_ready = 1'b1;
        reset      = 1'b1;
        #1;
    endtask

    task automatic apply_reset(input int new_lat);
        @(negedge clk);
        reset    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rst_mid.valid", 32'(ifid_valid), 32'd0);
        chk("rst_mid.req", 32'(imem_req), 32'd0);
        lat = new_lat;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.valid", 32'(ifid_valid), 32'd0);
        chk("rst.pc", 32'(ifid_pc), 32'd0);
        chk("rst.instr", ifid_instr, 32'd0);

        // ---- free run, 1-cycle memory ----
        release_reset();                          // W0
        chk_req("run0", 1'b1, 9'h000);
        chk("run0.valid", 32'(ifid_valid), 32'd0);
        for (int k = 1; k <= 5; k++) begin        // W1..W5
            step(1'b0, 1'b0, '0, 1'b1);
            chk_req($sformatf("run%0d", k), 1'b1, PC_W'(4 * k));
            if (k >= 2) begin
                chk_out($sformatf("run%0d", k), PC_W'(4 * (k - 2)));
            end else begin
                chk("run1.valid", 32'(ifid_valid), 32'd0);
            end
        end

        // ---- stall held 5 cycles (W6..W10) ----
        step(1'b1, 1'b0, '0, 1'b1);               // W6
        chk_out("stall6", 9'h010);
        chk_req("stall6", 1'b1, 9'h018);
        for (int k = 7; k <= 10; k++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            chk_out($sformatf("stall%0d", k), 9'h010);
            chk_req($sformatf("stall%0d", k), 1'b0, '0);
        end
        step(1'b0, 1'b0, '0, 1'b1);               // W11, release
        chk_out("rel11", 9'h010);
        chk_req("rel11", 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1);               // W12
        chk_out("rel12", 9'h014);
        chk_req("rel12", 1'b1, 9'h01C);
        step(1'b0, 1'b0, '0, 1'b1);               // W13
        chk_out("rel13", 9'h018);
        step(1'b0, 1'b0, '0, 1'b1);               // W14
        chk_out("rel14", 9'h01C);
        step(1'b0, 1'b0, '0, 1'b1);               // W15
        chk_out("rel15", 9'h020);

        // ---- redirect with 2 in flight, 3-cycle memory ----
        apply_reset(3);
        release_reset();                          // W0
        chk_req("rd0", 1'b1, 9'h000);
        step(1'b0, 1'b0, '0, 1'b1);               // W1
        chk_req("rd1", 1'b1, 9'h004);
        step(1'b0, 1'b0, '0, 1'b1);               // W2
        chk_req("rd2", 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1);               // W3
        step(1'b0, 1'b0, '0, 1'b1);               // W4
        chk_out("rd4", 9'h000);
        chk_req("rd4", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b1);               // W5
        chk_out("rd5", 9'h004);
        chk_req("rd5", 1'b1, 9'h00C);
        step(1'b0, 1'b1, 9'h100, 1'b1);           // W6, redirect
        chk_req("rd6", 1'b0, '0);
        for (int k = 7; k <= 11; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            chk($sformatf("rd%0d.valid", k), 32'(ifid_valid), 32'd0);
            if (k == 8) begin
                chk_req("rd8", 1'b1, 9'h100);
            end
        end
        step(1'b0, 1'b0, '0, 1'b1);               // W12
        chk_out("rd12", 9'h100);
        step(1'b0, 1'b0, '0, 1'b1);               // W13
        chk_out("rd13", 9'h104);

        // ---- redirect + stall with same-cycle response ----
        apply_reset(1);
        release_reset();                          // W0
        step(1'b0, 1'b0, '0, 1'b1);               // W1
        step(1'b1, 1'b1, 9'h040, 1'b1);           // W2, rvalid for 0x004
        chk_out("rs2", 9'h000);
        chk("rs2.rvalid", 32'(imem_rvalid), 32'd1);
        chk_req("rs2", 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1);               // W3
        chk("rs3.valid", 32'(ifid_valid), 32'd0);
        chk_req("rs3", 1'b1, 9'h040);
        step(1'b0, 1'b0, '0, 1'b1);               // W4
        chk("rs4.valid", 32'(ifid_valid), 32'd0);
        step(1'b0, 1'b1, 9'h1F8, 1'b1);           // W5, redirect for wrap test
        chk_out("rs5", 9'h040);

        // ---- PC wrap ----
        step(1'b0, 1'b0, '0, 1'b1);               // W6
        chk("wr6.valid", 32'(ifid_valid), 32'd0);
        chk_req("wr6", 1'b1, 9'h1F8);
        step(1'b0, 1'b0, '0, 1'b1);               // W7
        chk_req("wr7", 1'b1, 9'h1FC);
        step(1'b0, 1'b0, '0, 1'b1);               // W8
        chk_out("wr8", 9'h1F8);
        chk_req("wr8", 1'b1, 9'h000);
        step(1'b0, 1'b0, '0, 1'b1);               // W9
        chk_out("wr9", 9'h1FC);

        // ---- imem_ready low 4 cycles (W10..W13) ----
        step(1'b0, 1'b0, '0, 1'b0);               // W10
        chk_out("nr10", 9'h000);
        chk_req("nr10", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b0);               // W11
        chk_out("nr11", 9'h004);
        chk_req("nr11", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b0);               // W12
        chk("nr12.valid", 32'(ifid_valid), 32'd0);
        chk_req("nr12", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b0);               // W13
        chk("nr13.valid", 32'(ifid_valid), 32'd0);
        chk_req("nr13", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b1);               // W14
        chk("nr14.valid", 32'(ifid_valid), 32'd0);
        chk_req("nr14", 1'b1, 9'h008);
        step(1'b0, 1'b0, '0, 1'b1);               // W15
        chk("nr15.valid", 32'(ifid_valid), 32'd0);
        chk_req("nr15", 1'b1, 9'h00C);
        step(1'b0, 1'b0, '0, 1'b1);               // W16
        chk_out("nr16", 9'h008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
